pl_stage_chain: RTL and testbench
=================================

Name: pl_stage_chain

Overview:
- Parametrised, handshaked pipeline register chain.
- Generalises the fixed fetch/decode/execute/memory/writeback stage registers into one block:
  - WIDTH-bit payload, DEPTH stages.
  - A valid bit per stage, plus per-stage stall and flush.
  - Ready/valid at both ends, with bubble collapsing.
- Hazard control drives the stall/flush vectors. The block is used wherever a stall-able, flush-able stage sequence is needed.

Parameters:
- WIDTH, 32, payload bits per stage.
- DEPTH, 4, number of stages (>=1). Stage 0 is the input side; stage DEPTH-1 is the output side.
- RESET_DATA, 0, value loaded into every stage data register on reset.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream item present.
- in_ready  output  1  stage 0 can take an item this cycle.
- in_data  input  WIDTH  upstream payload.
- stall  input  DEPTH  stall[k]=1 freezes stage k.
- flush  input  DEPTH  flush[k]=1 kills stage k contents.
- out_valid  output  1  stage DEPTH-1 item offered.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  stage DEPTH-1 payload.
- stage_valid  output  DEPTH  valid bit of each stage.
- stage_data  output  DEPTH*WIDTH  stage k occupies bits [k*WIDTH +: WIDTH].
- occupancy  output  $clog2(DEPTH+1)  registered count of valid stages.

Behaviour:
- Reset (reset_n=0, no clock needed):
  - All v[k]=0, all d[k]=RESET_DATA, occupancy=0.
  - Hence out_valid=0 and stage_valid=0.
  - Reset mid-stream discards everything. First acceptance occurs on the first rising edge after reset_n rises.
- Definitions, combinational chain from out_ready back to in_ready, no registers in the ready path:
  - sink[DEPTH-1] = out_ready & ~flush[DEPTH-1].
  - sink[k] = free[k+1] for k<DEPTH-1.
  - go[k] = v[k] & ~stall[k] & ~flush[k] & sink[k]: item leaves stage k.
  - free[k] = flush[k] | (~stall[k] & (~v[k] | go[k])): stage k can take an item.
  - in_ready = free[0].
  - out_valid = v[DEPTH-1] & ~flush[DEPTH-1] & ~stall[DEPTH-1].
  - out_data = d[DEPTH-1].
- Register update at each edge, per stage k, where src is in_valid/in_data for k=0 and go[k-1]/d[k-1] otherwise:
  - If flush[k]: v[k]<=0. Any item arriving this cycle is consumed by the handshake and dropped. Flush overrides stall.
  - Else if stall[k]: v[k] and d[k] hold.
  - Else if the source item moves in: v[k]<=1 and d[k]<=source data.
  - Else if go[k]: v[k]<=0.
  - Else: hold.
- Data registers load only on an accepted move. Bubble contents are don't-care; stage_data shows the stale value.
- Latency: an item accepted at edge n with no stalls or backpressure appears on out_data/out_valid after edge n+DEPTH-1. Throughput is one item per cycle.
- Bubble collapse: an empty stage accepts from its predecessor even when later stages are blocked.
- Ordering: items never reorder or duplicate.
- Simultaneous accept and emit are allowed. When the chain is full with out_ready=1, in_ready=1.
- occupancy <= popcount of the next-state v vector.
- DEPTH=1: a single registered stage with the same rules.

Optional Feature:
- Macro PL_STAGE_CHAIN_PERF_EN.
- Defined adds output ports:
  - bp_cycles, 32 bits: counts cycles with v[DEPTH-1]=1 and out_ready=0.
  - flush_drops, 32 bits: counts items killed, i.e. valid residents plus arriving items per flushed stage each cycle.
  - Both saturate at 0xFFFFFFFF and reset to 0 with reset_n.
- Undefined: the ports and counters do not exist. Core behaviour is identical either way.

Test Plan (WIDTH=32, DEPTH=4):
- Stream: push 0x10,0x11,0x12 on consecutive edges 0-2 with out_ready=1 -> out_data 0x10,0x11,0x12 valid after edges 3,4,5. occupancy peaks at 3.
- Backpressure: out_ready=0, offer 0xA0..0xA4 -> 0xA0..0xA3 accepted, in_ready=0 while 0xA4 is offered, occupancy=4. Raise out_ready -> 0xA0..0xA4 emitted in order, no duplicates.
- Bubble collapse: stage contents {3:0xB0, 2:empty, 1:0xB1, 0:empty}, out_ready=0 -> next edge {3:0xB0, 2:0xB1}; in_ready stays 1 until all stages are valid.
- Flush: full chain {3:0xC3, 2:0xC2, 1:0xC1, 0:0xC0}, out_ready=1, flush=4'b0010 for one cycle, with 0xC4 offered at the input. Required:
  - Edge 1: 0xC3 emitted, stage3<=0xC2, stage2 receives nothing (0xC1 killed), stage1 empty (arriving 0xC0 dropped), stage0<=0xC4.
  - Outputs seen: 0xC3, 0xC2, then 0xC4. flush_drops=2 if the macro is enabled.
- Stall: continuous stream, stall=4'b0100 for 3 cycles -> stage2 holds its value, stage3 drains then empties, stages0-1 fill, and in_ready drops to 0. Releasing the stall resumes order.
- Async reset: assert reset_n=0 between edges with the chain full -> stage_valid=0, out_valid=0, occupancy=0 immediately, before any edge.

Source files
------------

// File: rtl/pl_stage_chain.sv
// Parametrised ready/valid pipeline register chain with per-stage stall/flush and bubble collapse.
// Optional performance counters (bp_cycles, flush_drops) are built when PL_STAGE_CHAIN_PERF_EN is defined.
module pl_stage_chain #(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      DEPTH      = 4,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [DEPTH-1:0]           stall,
    input  logic [DEPTH-1:0]           flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [DEPTH-1:0]           stage_valid,
    output logic [DEPTH*WIDTH-1:0]     stage_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef PL_STAGE_CHAIN_PERF_EN
    ,
    output logic [31:0]                bp_cycles,
    output logic [31:0]                flush_drops
`endif
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] r_v;
    logic [WIDTH-1:0] r_d [DEPTH];
    logic [OCC_W-1:0] r_occ;

    logic [DEPTH-1:0] w_go;
    logic [DEPTH-1:0] w_free;
    logic [DEPTH-1:0] w_arrive;
    logic [DEPTH-1:0] w_load;
    logic [DEPTH-1:0] w_v_next;
    logic [OCC_W-1:0] w_occ_next;

    // Ready ripples from the output back to the input with no register in the path.
    always_comb begin : ready_chain
        logic w_sink;
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_go   = '0;
        w_free = '0;
        w_sink = out_ready & ~flush[DEPTH-1];
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_go[k]   = r_v[k] & ~stall[k] & ~flush[k] & w_sink;
            w_free[k] = flush[k] | (~stall[k] & (~r_v[k] | w_go[k]));
            w_sink    = w_free[k];
        end
    end

    always_comb begin : next_state
        w_arrive    = '0;
        w_load      = '0;
        w_v_next    = r_v;
        w_occ_next  = '0;
        w_arrive[0] = in_valid & w_free[0];
        for (int k = 1; k < DEPTH; k++) begin
            w_arrive[k] = w_go[k-1];
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (flush[k]) begin
                w_v_next[k] = 1'b0;
            end else if (stall[k]) begin
                w_v_next[k] = r_v[k];
            end else if (w_arrive[k]) begin
                w_v_next[k] = 1'b1;
                w_load[k]   = 1'b1;
            end else if (w_go[k]) begin
                w_v_next[k] = 1'b0;
            end
            w_occ_next = w_occ_next + OCC_W'(w_v_next[k]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v   <= '0;
            r_occ <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all stages sample pre-edge values.
            r_v   <= w_v_next;
            r_occ <= w_occ_next;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] w_src;
        if (k == 0) begin : g_first
            assign w_src = in_data;
        end else begin : g_next
            assign w_src = r_d[k-1];
        end

        // NOTE: the data registers are reset too, so stage_data shows RESET_DATA rather than X after reset.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_d[k] <= RESET_DATA;
            end else if (w_load[k]) begin
                r_d[k] <= w_src;
            end
        end

        assign stage_data[k*WIDTH +: WIDTH] = r_d[k];
    end

    assign in_ready    = w_free[0];
    assign out_valid   = r_v[DEPTH-1] & ~flush[DEPTH-1] & ~stall[DEPTH-1];
    assign out_data    = r_d[DEPTH-1];
    assign stage_valid = r_v;
    assign occupancy   = r_occ;

`ifdef PL_STAGE_CHAIN_PERF_EN
    logic [31:0] r_bp;
    logic [31:0] r_fd;
    logic [31:0] w_drop_cnt;
    logic [32:0] w_fd_sum;

    // Killed items per cycle: residents of flushed stages plus whatever was arriving into them.
    always_comb begin
        w_drop_cnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (flush[k]) begin
                w_drop_cnt = w_drop_cnt + 32'(r_v[k]) + 32'(w_arrive[k]);
            end
        end
        w_fd_sum = {1'b0, r_fd} + {1'b0, w_drop_cnt};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bp <= '0;
            r_fd <= '0;
        end else begin
            if (r_v[DEPTH-1] && !out_ready && (r_bp != 32'hFFFF_FFFF)) begin
                r_bp <= r_bp + 32'd1;
            end
            r_fd <= w_fd_sum[32] ? 32'hFFFF_FFFF : w_fd_sum[31:0];
        end
    end

    assign bp_cycles   = r_bp;
    assign flush_drops = r_fd;
`endif

endmodule

// File: tb/tb_pl_stage_chain.sv
// Self-checking bench for pl_stage_chain: directed scenarios plus randomized traffic against a slot model.
module tb_pl_stage_chain;

    localparam int W = 32;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic [D-1:0]   stall;
    logic [D-1:0]   flush;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [D-1:0]   stage_valid;
    logic [D*W-1:0] stage_data;
    logic [2:0]     occupancy;
`ifdef PL_STAGE_CHAIN_PERF_EN
    logic [31:0]    bp_cycles;
    logic [31:0]    flush_drops;
`endif

    always #5 clk = ~clk;

    pl_stage_chain #(.WIDTH(W), .DEPTH(D), .RESET_DATA('0)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .stall       (stall),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .stage_valid (stage_valid),
        .stage_data  (stage_data),
        .occupancy   (occupancy)
`ifdef PL_STAGE_CHAIN_PERF_EN
        ,
        .bp_cycles   (bp_cycles),
        .flush_drops (flush_drops)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one slot per stage, moved procedurally each cycle.
    bit           mv [D];
    logic [W-1:0] md [D];
    int unsigned  m_bp;
    int unsigned  m_drops;

    logic [W-1:0] got_q [$];
    bit           chk_order;
    bit           have_last;
    logic [W-1:0] last_out;
    bit           last_acc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] sd(input int k);
        return stage_data[k*W +: W];
    endfunction

    task automatic step(input bit iv, input logic [W-1:0] id, input logic [D-1:0] st,
                        input logic [D-1:0] fl, input bit ordy);
        bit           leaves [D];
        bit           opens  [D];
        bit           arrive [D];
        bit           nv     [D];
        logic [W-1:0] nd     [D];
        bit           down_open;
        bit           exp_ov;
        int           occ;
        logic [D-1:0] ev;

        in_valid  = iv;
        in_data   = id;
        stall     = st;
        flush     = fl;
        out_ready = ordy;
        #1;
        down_open = ordy && !fl[D-1];
        for (int k = D - 1; k >= 0; k--) begin
            leaves[k] = mv[k] && !st[k] && !fl[k] && down_open;
            opens[k]  = fl[k] || (!st[k] && (!mv[k] || leaves[k]));
            down_open = opens[k];
        end
        exp_ov = mv[D-1] && !st[D-1] && !fl[D-1];
        check("in_ready", in_ready, opens[0]);
        check("out_valid", out_valid, exp_ov);
        if (exp_ov) check("out_data", out_data, md[D-1]);
        last_acc = iv && opens[0];
        if (exp_ov && ordy) begin
            got_q.push_back(out_data);
            if (chk_order && have_last) check("order", out_data > last_out, 1);
            last_out  = out_data;
            have_last = 1'b1;
        end
        for (int k = 0; k < D; k++) begin
            if (k == 0) arrive[k] = last_acc;
            else        arrive[k] = leaves[k-1];
            nv[k] = mv[k];
            nd[k] = md[k];
            if (fl[k]) begin
                nv[k] = 1'b0;
                if (mv[k])     m_drops++;
                if (arrive[k]) m_drops++;
            end else if (!st[k]) begin
                if (arrive[k]) begin
                    nv[k] = 1'b1;
                    nd[k] = (k == 0) ? id : md[k-1];
                end else if (leaves[k]) begin
                    nv[k] = 1'b0;
                end
            end
        end
        if (mv[D-1] && !ordy) m_bp++;

        @(posedge clk);
        #1;
        occ = 0;
        for (int k = 0; k < D; k++) begin
            mv[k] = nv[k];
            md[k] = nd[k];
            ev[k] = nv[k];
            occ += int'(nv[k]);
        end
        check("stage_valid", stage_valid, ev);
        check("occupancy", occupancy, occ);
        for (int k = 0; k < D; k++) begin
            if (mv[k]) check($sformatf("stage_data%0d", k), sd(k), md[k]);
        end
`ifdef PL_STAGE_CHAIN_PERF_EN
        check("bp_cycles", bp_cycles, m_bp);
        check("flush_drops", flush_drops, m_drops);
`endif
    endtask

    // Called away from the edge; checks that reset acts without any clock.
    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        stall     = '0;
        flush     = '0;
        out_ready = 1'b0;
        reset_n   = 1'b0;
        #1;
        check("rst_stage_valid", stage_valid, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_in_ready", in_ready, 1);
        for (int k = 0; k < D; k++) check($sformatf("rst_data%0d", k), sd(k), 0);
        for (int k = 0; k < D; k++) begin
            mv[k] = 1'b0;
            md[k] = '0;
        end
        m_bp      = 0;
        m_drops   = 0;
        have_last = 1'b0;
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] idx;
        logic [W-1:0] seq;
        logic [D-1:0] st;
        logic [D-1:0] fl;

        chk_order = 1'b0;
        do_reset();

        // Stream: three items back to back, latency DEPTH-1 edges.
        step(1'b1, 32'h10, '0, '0, 1'b1);
        step(1'b1, 32'h11, '0, '0, 1'b1);
        step(1'b1, 32'h12, '0, '0, 1'b1);
        check("stream_occ_peak", occupancy, 3);
        step(1'b0, '0, '0, '0, 1'b1);
        check("stream_out0", {out_valid, out_data}, {1'b1, 32'h10});
        step(1'b0, '0, '0, '0, 1'b1);
        check("stream_out1", {out_valid, out_data}, {1'b1, 32'h11});
        step(1'b0, '0, '0, '0, 1'b1);
        check("stream_out2", {out_valid, out_data}, {1'b1, 32'h12});
        step(1'b0, '0, '0, '0, 1'b1);
        check("stream_empty", out_valid, 0);

        // Backpressure: four accepted, fifth blocked, then drained in order.
        do_reset();
        chk_order = 1'b1;
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'hA0 + idx, '0, '0, 1'b0);
            if (last_acc) idx++;
        end
        check("bp_in_ready", in_ready, 0);
        check("bp_occupancy", occupancy, 4);
        got_q.delete();
        for (int i = 0; i < 8; i++) begin
            step(idx < 5, 32'hA0 + idx, '0, '0, 1'b1);
            if (last_acc) idx++;
        end
        check("bp_count", got_q.size(), 5);
        for (int i = 0; i < 5 && i < got_q.size(); i++)
            check($sformatf("bp_item%0d", i), got_q[i], 32'hA0 + i);

        // Bubble collapse with the output blocked.
        do_reset();
        step(1'b1, 32'hB0, '0, '0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b0);
        step(1'b1, 32'hB1, '0, '0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b0);
        check("bubble_shape", stage_valid, 4'b1010);
        check("bubble_s3", sd(3), 32'hB0);
        check("bubble_s1", sd(1), 32'hB1);
        check("bubble_in_ready", in_ready, 1);
        step(1'b0, '0, '0, '0, 1'b0);
        check("bubble_collapse", stage_valid, 4'b1100);
        check("bubble_s2", sd(2), 32'hB1);
        step(1'b1, 32'hB2, '0, '0, 1'b0);
        step(1'b1, 32'hB3, '0, '0, 1'b0);
        check("bubble_full", stage_valid, 4'b1111);
        check("bubble_blocked", in_ready, 0);

        // Flush of stage 1 on a full chain while emitting and accepting.
        do_reset();
        chk_order = 1'b0;
        step(1'b1, 32'hC3, '0, '0, 1'b0);
        step(1'b1, 32'hC2, '0, '0, 1'b0);
        step(1'b1, 32'hC1, '0, '0, 1'b0);
        step(1'b1, 32'hC0, '0, '0, 1'b0);
        check("flush_full", stage_valid, 4'b1111);
        got_q.delete();
        step(1'b1, 32'hC4, '0, 4'b0010, 1'b1);
        check("flush_shape", stage_valid, 4'b1001);
        check("flush_s3", sd(3), 32'hC2);
        check("flush_s0", sd(0), 32'hC4);
        for (int i = 0; i < 5; i++) step(1'b0, '0, '0, '0, 1'b1);
        check("flush_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("flush_out0", got_q[0], 32'hC3);
            check("flush_out1", got_q[1], 32'hC2);
            check("flush_out2", got_q[2], 32'hC4);
        end
`ifdef PL_STAGE_CHAIN_PERF_EN
        check("flush_drops_total", flush_drops, 2);
`endif

        // Stall of stage 2 in a continuous stream.
        do_reset();
        chk_order = 1'b1;
        seq = 32'h60;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, seq, '0, '0, 1'b1);
            if (last_acc) seq++;
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, seq, 4'b0100, '0, 1'b1);
            if (last_acc) seq++;
            if (i == 0) check("stall_drain", stage_valid, 4'b0111);
        end
        check("stall_in_ready", in_ready, 0);
        check("stall_hold", stage_valid, 4'b0111);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, seq, '0, '0, 1'b1);
            if (last_acc) seq++;
        end

        // Asynchronous reset with the chain full, checked inside do_reset before any edge.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 32'hE0 + i, '0, '0, 1'b0);
        check("pre_reset_full", occupancy, 4);
        do_reset();

        // Randomized traffic against the model.
        chk_order = 1'b1;
        seq = 32'h1000;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < D; k++) begin
                st[k] = ($urandom_range(0, 7) == 0);
                fl[k] = ($urandom_range(0, 15) == 0);
            end
            step($urandom_range(0, 3) != 0, seq, st, fl, $urandom_range(0, 9) < 7);
            if (last_acc) seq++;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
